// File: rtl/smc_float_to_fp.sv
// SMC float to signed fixed-point converter: decode, align, then round/saturate/sign.
// Three registered stages, one sample per clock, valid travels alongside the data.
module smc_float_to_fp #(
  parameter int OUT_W  = 32,
  parameter int FRAC_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_srdyi,
  input  logic [31:0]      i_x,
  output logic [OUT_W-1:0] o_y,
  output logic             o_srdyo,
  output logic             o_ovf
);

  localparam int MW = OUT_W + 1;
  localparam int WW = MW + 24;
  localparam logic [MW:0] POS_LIM = {3'b000, {(OUT_W-1){1'b1}}};
  localparam logic [MW:0] NEG_LIM = {3'b001, {(OUT_W-1){1'b0}}};

  // stage 1: decode
  logic              v1, sgn1, zero1, spec1;
  logic [23:0]       man1;
  logic signed [9:0] sh1;
  logic signed [9:0] sh_d;

  assign sh_d = $signed({2'b00, i_x[30:23]}) - 10'sd150 + $signed(10'(FRAC_W));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      v1    <= 1'b0;
      sgn1  <= 1'b0;
      zero1 <= 1'b0;
      spec1 <= 1'b0;
      man1  <= '0;
      sh1   <= '0;
    end else begin
      v1 <= i_srdyi;
      if (i_srdyi) begin
        sgn1  <= i_x[31];
        zero1 <= (i_x[30:23] == 8'h00);
        spec1 <= (i_x[30:23] == 8'hFF);
        man1  <= {1'b1, i_x[22:0]};
        sh1   <= sh_d;
      end
    end
  end

  // stage 2: align
  logic [WW-1:0] wide;
  logic [24:0]   rs;
  logic [7:0]    rsh;
  logic [MW-1:0] mag_d;
  logic          big_d, rnd_d;

  // For sh1 <= MW the hidden bit still lands inside 'wide', so its upper bits
  // capture every lost bit exactly; larger shifts are always too big.
  always_comb begin
    wide  = '0;
    rs    = '0;
    rsh   = '0;
    mag_d = '0;
    big_d = 1'b0;
    rnd_d = 1'b0;
    if (!sh1[9]) begin
      wide  = WW'(man1) << sh1[8:0];
      mag_d = wide[MW-1:0];
      big_d = (int'(sh1) > MW) || (|wide[WW-1:MW]);
    end else begin
      rsh   = 8'(-sh1);
      rs    = {man1, 1'b0} >> rsh;
      mag_d = MW'(rs[24:1]);
      rnd_d = rs[0];
    end
  end

  logic          v2, sgn2, zero2, spec2, big2, rnd2;
  logic [MW-1:0] mag2;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      v2    <= 1'b0;
      sgn2  <= 1'b0;
      zero2 <= 1'b0;
      spec2 <= 1'b0;
      big2  <= 1'b0;
      rnd2  <= 1'b0;
      mag2  <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        sgn2  <= sgn1;
        zero2 <= zero1;
        spec2 <= spec1;
        big2  <= big_d;
        rnd2  <= rnd_d;
        mag2  <= mag_d;
      end
    end
  end

  // stage 3: round half away from zero, saturate, apply sign
  logic [MW:0]      sum, lim, res;
  logic             ovf_d;
  logic [OUT_W-1:0] y_d;

  always_comb begin
    sum   = {1'b0, mag2} + (MW+1)'(rnd2);
    lim   = sgn2 ? NEG_LIM : POS_LIM;
    ovf_d = spec2 || big2 || (sum > lim);
    res   = ovf_d ? lim : sum;
    y_d   = sgn2 ? -res[OUT_W-1:0] : res[OUT_W-1:0];
    if (zero2) begin
      ovf_d = 1'b0;
      y_d   = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_y     <= '0;
      o_ovf   <= 1'b0;
      o_srdyo <= 1'b0;
    end else begin
      o_srdyo <= v2;
      if (v2) begin
        o_y   <= y_d;
        o_ovf <= ovf_d;
      end
    end
  end

endmodule

// File: doc/smc_float_to_fp.md
Name: smc_float_to_fp

Overview:
- Output-side converter of the NLC datapath; inverse of the fixed-point-to-SMC-float input converter.
- Takes the 32-bit SMC float result of the correction polynomial (accumulator value) and produces a signed two's-complement fixed-point voltage word.
- Includes rounding, saturation and an overflow flag.
- 3-stage pipeline, one sample per clock, srdyi/srdyo valid handshake as used by the other SMC float units.

Parameters:
- OUT_W, 32: output word width, two's complement.
- FRAC_W, 16: number of fractional bits in o_y. Legal range 0 to OUT_W-1.

Ports:
- i_clk  input  1  system clock; all flops on the rising edge.
- i_reset  input  1  global reset, asynchronous, active-low.
- i_srdyi  input  1  input valid; one sample is accepted per cycle in which it is high.
- i_x  input  32  SMC float. Bit 31 is the sign, bits 30:23 the exponent (bias 127), bits 22:0 the mantissa with a hidden 1.
- o_y  output  OUT_W  fixed-point result, value = round(x * 2^FRAC_W).
- o_srdyo  output  1  result valid; a one-cycle pulse per accepted sample.
- o_ovf  output  1  saturation or special-value flag, aligned with o_srdyo.

Behaviour:
- Reset (i_reset=0, asynchronous): o_y=0, o_srdyo=0, o_ovf=0, all stage valids=0. Reset asserted mid-operation discards in-flight samples. No output pulse follows reset release until new i_srdyi samples have traversed the pipe.
- Latency: a sample captured at rising edge k drives o_srdyo=1 in the cycle following edge k+2 (3 edges).
- Throughput: back-to-back i_srdyi is fully supported. There is no stall or back-pressure.
- o_srdyo is high for exactly one cycle per sample.
- When o_srdyo=0, o_y and o_ovf hold their last values.
- Stage 1 (decode):
  - Capture the sign S, exponent E and mantissa M = {1, mantissa} (24 bits).
  - Class ZERO when E=0 (denormals flush to zero). Class SPECIAL when E=255 (Inf or NaN).
  - Compute shift s = E - 150 + FRAC_W as a signed 10-bit value.
- Stage 2 (align):
  - If s>=0: magnitude = M << s, computed at OUT_W+1 bits. Mark big if any bit would be lost or if the magnitude exceeds the limit.
  - If s<0 and -s<=24: magnitude = M >> -s. The round bit is M[-s-1].
  - If -s>24: magnitude=0 and the round bit is 0. This includes -s=25, where the round bit falls beyond the MSB.
- Stage 3 (round, saturate, sign):
  - Rounding is half away from zero: magnitude += round bit.
  - The positive limit is 2^(OUT_W-1)-1. The negative limit is 2^(OUT_W-1), so the most negative code is reachable without flagging.
  - If big, or magnitude > limit: clamp to the limit and set o_ovf=1. This includes a carry out of the rounding add.
  - SPECIAL: clamp to the limit by sign and set o_ovf=1. NaN is treated as Inf of its sign.
  - ZERO: o_y=0 and o_ovf=0, including the -0 input.
  - o_y = S ? -magnitude : magnitude.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset and basic conversion, OUT_W=32, FRAC_W=16: hold i_reset=0, then release; i_x=0x3F800000 (1.0) with one i_srdyi pulse -> after 3 edges o_y=0x00010000, o_ovf=0, o_srdyo high for 1 cycle.
- Negative value and streaming: i_x=0xC0200000 (-2.5), 0x00000000, 0x80000000 on consecutive cycles -> o_y=0xFFFD8000, 0, 0 on 3 consecutive cycles, all with o_ovf=0.
- Rounding at the LSB: 0x37000000 (2^-17) -> o_y=1; 0x36800000 (2^-18) -> o_y=0; 0xB7000000 -> o_y=0xFFFFFFFF.
- Saturation: 0x471C4000 (40000.0) -> 0x7FFFFFFF, o_ovf=1; 0xC7000000 (-32768.0) -> 0x80000000, o_ovf=0; 0xC7000100 -> 0x80000000, o_ovf=1.
- Special values: 0x7FC00000 (NaN) -> 0x7FFFFFFF, o_ovf=1; 0xFF800000 (-Inf) -> 0x80000000, o_ovf=1; 0x00400000 (denormal) -> 0, o_ovf=0.
- Reset mid-pipeline: 3 samples in flight, assert i_reset=0 for 1 cycle between edges -> no o_srdyo pulse afterwards, o_y=0 immediately on assertion, next new sample converts correctly.
